// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: reset-vector fetch, then PC hold/increment/load/jump.
// Optional odd-target detection is built when PC_ALIGN_TRAP_EN is defined.
module pc_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFE,
    parameter logic [15:0] PC_INIT      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  MPC,
    input  logic [2:0]  jcond,
    input  logic [9:0]  joff,
    input  logic [3:0]  sr_flags,
    input  logic [15:0] pc_load,
    input  logic [15:0] MDB_out,
    output logic [15:0] MAB,
    output logic [15:0] PC,
    output logic        fetch_valid,
    output logic        jump_taken,
    output logic        pc_misalign
);

    typedef enum logic [1:0] {RST_HOLD, VEC_ADDR, VEC_LOAD, RUN} state_t;

    state_t      state, state_next;
    logic [15:0] pc_q;
    logic [15:0] pc_raw;
    logic [15:0] jump_target;
    logic        pc_write;
    logic        cond_met;
    logic        taken;

    logic flag_v, flag_n, flag_z, flag_c;
    assign {flag_v, flag_n, flag_z, flag_c} = sr_flags;

    always_comb begin
        cond_met = 1'b0;
        case (jcond)
            3'b000:  cond_met = !flag_z;
            3'b001:  cond_met = flag_z;
            3'b010:  cond_met = !flag_c;
            3'b011:  cond_met = flag_c;
            3'b100:  cond_met = flag_n;
            3'b101:  cond_met = !(flag_n ^ flag_v);
            3'b110:  cond_met = flag_n ^ flag_v;
            default: cond_met = 1'b1;
        endcase
    end

    // Word offset: sign-extend the 10-bit field, then scale by two.
    assign jump_target = pc_q + 16'd2 + {{5{joff[9]}}, joff, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_raw      = pc_q;
        pc_write    = 1'b0;
        taken       = 1'b0;
        MAB         = pc_q;
        fetch_valid = 1'b0;
        case (state)
            RST_HOLD: state_next = VEC_ADDR;
            VEC_ADDR: begin
                MAB        = RESET_VECTOR;
                state_next = VEC_LOAD;
            end
            VEC_LOAD: begin
                MAB        = RESET_VECTOR;
                pc_raw     = MDB_out;
                pc_write   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                fetch_valid = 1'b1;
                case (MPC)
                    3'd1: begin
                        pc_raw   = pc_q + 16'd2;
                        pc_write = 1'b1;
                    end
                    3'd2: begin
                        pc_raw   = pc_load;
                        pc_write = 1'b1;
                    end
                    3'd3: begin
                        taken    = cond_met;
                        pc_raw   = cond_met ? jump_target : pc_q + 16'd2;
                        pc_write = 1'b1;
                    end
                    default: pc_write = 1'b0;
                endcase
            end
            default: state_next = RST_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= PC_INIT;
            jump_taken <= 1'b0;
        end else begin
            if (pc_write) begin
                pc_q <= pc_raw & 16'hFFFE;
            end
            jump_taken <= taken;
        end
    end

    assign PC = pc_q;

`ifdef PC_ALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (pc_write && pc_raw[0]) begin
            misalign_q <= 1'b1;
        end
    end

    assign pc_misalign = misalign_q;
`else
    assign pc_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a reference model pushes expected outputs per cycle,
// a monitor pops and compares them one time unit after each rising edge.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  MPC = '0;
    logic [2:0]  jcond = '0;
    logic [9:0]  joff = '0;
    logic [3:0]  sr_flags = '0;
    logic [15:0] pc_load = '0;
    logic [15:0] MDB_out = 16'hC000;
    logic [15:0] MAB;
    logic [15:0] PC;
    logic        fetch_valid;
    logic        jump_taken;
    logic        pc_misalign;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

`ifdef PC_ALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    pc_fetch #(.RESET_VECTOR(16'hFFFE), .PC_INIT(16'h0000)) dut (
        .clk(clk), .rst(rst), .MPC(MPC), .jcond(jcond), .joff(joff),
        .sr_flags(sr_flags), .pc_load(pc_load), .MDB_out(MDB_out),
        .MAB(MAB), .PC(PC), .fetch_valid(fetch_valid),
        .jump_taken(jump_taken), .pc_misalign(pc_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] mab;
        logic        fv;
        logic        jt;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    // Reference model state: 0 hold, 1 vector address, 2 vector load, 3 run.
    int          m_state = 0;
    logic [15:0] m_pc = 16'h0000;
    logic        m_jt = 1'b0;
    logic        m_mis = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 16'h0000;
        m_jt    = 1'b0;
        m_mis   = 1'b0;
    endtask

    // Drive one cycle of inputs at the falling edge and predict the post-edge outputs.
    task automatic step(input logic [2:0] mpc, input logic [2:0] jc, input logic [9:0] off,
                        input logic [3:0] fl, input logic [15:0] ld);
        logic [15:0]        raw;
        logic signed [15:0] soff;
        logic               wr;
        logic               ok;
        logic               v, n, z, c;
        exp_t               e;
        @(negedge clk);
        MPC = mpc; jcond = jc; joff = off; sr_flags = fl; pc_load = ld;
        raw = m_pc; wr = 1'b0; ok = 1'b0;
        {v, n, z, c} = fl;
        case (m_state)
            0: m_state = 1;
            1: m_state = 2;
            2: begin raw = MDB_out; wr = 1'b1; m_state = 3; end
            default: begin
                if (mpc == 3'd1) begin
                    raw = m_pc + 16'd2; wr = 1'b1;
                end else if (mpc == 3'd2) begin
                    raw = ld; wr = 1'b1;
                end else if (mpc == 3'd3) begin
                    case (jc)
                        3'd0: ok = ~z;
                        3'd1: ok = z;
                        3'd2: ok = ~c;
                        3'd3: ok = c;
                        3'd4: ok = n;
                        3'd5: ok = (n == v);
                        3'd6: ok = (n != v);
                        default: ok = 1'b1;
                    endcase
                    soff = $signed(off);
                    raw = ok ? m_pc + 16'd2 + {soff[14:0], 1'b0} : m_pc + 16'd2;
                    wr = 1'b1;
                end
            end
        endcase
        if (wr) begin
            if (raw[0] && TRAP) m_mis = 1'b1;
            m_pc = {raw[15:1], 1'b0};
        end
        m_jt = ok;
        e.pc  = m_pc;
        e.mab = (m_state == 1 || m_state == 2) ? 16'hFFFE : m_pc;
        e.fv  = (m_state == 3);
        e.jt  = m_jt;
        e.mis = m_mis;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pc", PC, e.pc);
            check("mab", MAB, e.mab);
            check("fetch_valid", {15'd0, fetch_valid}, {15'd0, e.fv});
            check("jump_taken", {15'd0, jump_taken}, {15'd0, e.jt});
            check("pc_misalign", {15'd0, pc_misalign}, {15'd0, e.mis});
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, PC, 16'h0000);
        check({tag, "_mab"}, MAB, 16'h0000);
        check({tag, "_fv"}, {15'd0, fetch_valid}, 16'd0);
        check({tag, "_jt"}, {15'd0, jump_taken}, 16'd0);
        check({tag, "_mis"}, {15'd0, pc_misalign}, 16'd0);
    endtask

    task automatic after_edge_check(input string tag, input logic [15:0] got_sel, input logic [15:0] exp);
        check(tag, got_sel, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        check_reset_outputs("reset");

        // Release between edges; MPC=1 during the vector fetch must be ignored.
        @(posedge clk); #2; rst = 1'b0;
        repeat (3) step(3'd1, 3'd0, 10'd0, 4'd0, 16'd0);
        @(posedge clk); #2;
        check("vec_pc", PC, 16'hC000);
        check("vec_mab", MAB, 16'hC000);

        repeat (3) step(3'd1, 3'd0, 10'd0, 4'd0, 16'd0);
        repeat (2) step(3'd0, 3'd0, 10'd0, 4'd0, 16'd0);
        step(3'd5, 3'd0, 10'd0, 4'd0, 16'd0);
        @(posedge clk); #2;
        check("seq_pc", PC, 16'hC006);

        // JEQ backwards with Z set, then one idle cycle to see the pulse drop.
        step(3'd3, 3'b001, 10'h3FE, 4'b0010, 16'd0);
        @(posedge clk); #2;
        check("jeq_taken_pc", PC, 16'hC004);
        check("jeq_taken_jt", {15'd0, jump_taken}, 16'd1);
        step(3'd0, 3'd0, 10'd0, 4'd0, 16'd0);
        step(3'd2, 3'd0, 10'd0, 4'd0, 16'hC006);
        step(3'd3, 3'b001, 10'h3FE, 4'b0000, 16'd0);
        @(posedge clk); #2;
        check("jeq_not_pc", PC, 16'hC008);
        check("jeq_not_jt", {15'd0, jump_taken}, 16'd0);

        step(3'd2, 3'd0, 10'd0, 4'd0, 16'h0200);
        step(3'd3, 3'b101, 10'h010, 4'b1100, 16'd0);
        @(posedge clk); #2;
        check("jge_pc", PC, 16'h0222);
        step(3'd2, 3'd0, 10'd0, 4'd0, 16'h0200);
        step(3'd3, 3'b110, 10'h010, 4'b1100, 16'd0);
        @(posedge clk); #2;
        check("jl_pc", PC, 16'h0202);

        for (int i = 0; i < 24; i++) begin
            step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 10'($urandom),
                 4'($urandom), 16'($urandom));
        end

        step(3'd2, 3'd0, 10'd0, 4'd0, 16'h1235);
        @(posedge clk); #2;
        check("load_pc", PC, 16'h1234);
        check("load_mis", {15'd0, pc_misalign}, {15'd0, TRAP});
        step(3'd2, 3'd0, 10'd0, 4'd0, 16'hFFFE);
        step(3'd1, 3'd0, 10'd0, 4'd0, 16'd0);
        @(posedge clk); #2;
        check("wrap_pc", PC, 16'h0000);
        step(3'd3, 3'b111, 10'h1FF, 4'd0, 16'd0);
        step(3'd3, 3'b111, 10'h200, 4'd0, 16'd0);

        // Asynchronous reset between edges, then a fresh (odd) vector.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("async_reset");
        MDB_out = 16'hA5A1;
        @(posedge clk); #2;
        check_reset_outputs("held_reset");
        rst = 1'b0;
        repeat (3) step(3'd0, 3'd0, 10'd0, 4'd0, 16'd0);
        step(3'd1, 3'd0, 10'd0, 4'd0, 16'd0);
        @(posedge clk); #2;
        check("revec_pc", PC, 16'hA5A2);
        check("revec_mis", {15'd0, pc_misalign}, {15'd0, TRAP});

        @(posedge clk); #2;
        check("sb_drain", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
